// File: rtl/sevenseg_display_ctrl.sv
// Two-requester scheduler for a two-digit seven-segment display: arbitration with minimum
// hold, binary-to-BCD by iterative subtraction, scan strobe. Option: SEVENSEG_LEAD_BLANK_EN.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// S_IDLE    | no owner yet, digits blank, first request wins (timer on tie)
// S_CONVERT | subtract-10 loop on the latched value, digits frozen
// S_SHOW    | digits displayed, hold counter running, arbitration active
module sevenseg_display_ctrl #(
    parameter int CLK_DIV     = 100000,
    parameter int HOLD_CYCLES = 50000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tmr_req,
    input  logic [6:0] tmr_val,
    input  logic       score_req,
    input  logic [6:0] score_val,
    output logic       tmr_gnt,
    output logic       score_gnt,
    output logic       owner,
    output logic       busy,
    output logic       scan_en,
    output logic [3:0] d3,
    output logic [3:0] d2,
    output logic [3:0] d1,
    output logic [3:0] d0
);

    localparam int PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int HW = $clog2(HOLD_CYCLES + 2);
    localparam logic [PW-1:0] PRE_LAST = PW'(CLK_DIV - 1);
    localparam logic [HW-1:0] HOLD_MAX = HW'(HOLD_CYCLES);
    localparam logic [3:0]    BLANK    = 4'hF;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_CONVERT = 2'd1,
        S_SHOW    = 2'd2
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [PW-1:0]   pre_cnt;
    logic [PW-1:0]   pre_nxt;
    logic [HW-1:0]   hold;
    logic [6:0]      rem;
    logic [3:0]      tens;
    logic            grant_tmr;
    logic            grant_score;
    logic            hold_clr;
    logic [6:0]      sel_val;
    logic [6:0]      sat_val;
    logic [3:0]      tens_digit;

    // scan_en is registered from the same next count so it tracks count==CLK_DIV-1
    // exactly while still being forced low during reset.
    assign pre_nxt = (pre_cnt == PRE_LAST) ? '0 : pre_cnt + 1'b1;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pre_cnt <= '0;
            scan_en <= 1'b0;
        end else begin
            pre_cnt <= pre_nxt;
            scan_en <= (pre_nxt == PRE_LAST);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        grant_tmr   = 1'b0;
        grant_score = 1'b0;
        hold_clr    = 1'b0;
        case (state)
            S_IDLE: begin
                if (tmr_req) begin
                    grant_tmr = 1'b1;
                end else if (score_req) begin
                    grant_score = 1'b1;
                end
                hold_clr = tmr_req | score_req;
            end
            S_CONVERT: begin
                if (rem < 7'd10) begin
                    state_nxt = S_SHOW;
                end
            end
            S_SHOW: begin
                // The non-owner wins once hold has expired; the owner may refresh any time.
                if (owner) begin
                    if (tmr_req && (hold == HOLD_MAX)) begin
                        grant_tmr = 1'b1;
                        hold_clr  = 1'b1;
                    end else if (score_req) begin
                        grant_score = 1'b1;
                    end
                end else begin
                    if (score_req && (hold == HOLD_MAX)) begin
                        grant_score = 1'b1;
                        hold_clr    = 1'b1;
                    end else if (tmr_req) begin
                        grant_tmr = 1'b1;
                    end
                end
            end
            default: state_nxt = S_IDLE;
        endcase
        if (grant_tmr || grant_score) begin
            state_nxt = S_CONVERT;
        end
    end

    always_comb begin
        busy    = (state == S_CONVERT);
        d3      = BLANK;
        d2      = BLANK;
        sel_val = grant_score ? score_val : tmr_val;
        sat_val = (sel_val > 7'd99) ? 7'd99 : sel_val;
`ifdef SEVENSEG_LEAD_BLANK_EN
        tens_digit = (tens == 4'd0) ? BLANK : tens;
`else
        tens_digit = tens;
`endif
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tmr_gnt   <= 1'b0;
            score_gnt <= 1'b0;
            owner     <= 1'b0;
            hold      <= '0;
            rem       <= '0;
            tens      <= '0;
            d1        <= BLANK;
            d0        <= BLANK;
        end else begin
            tmr_gnt   <= grant_tmr;
            score_gnt <= grant_score;
            if (hold_clr) begin
                hold <= '0;
            end else if ((state == S_SHOW) && (hold != HOLD_MAX)) begin
                hold <= hold + 1'b1;
            end
            if (grant_tmr || grant_score) begin
                owner <= grant_score;
                rem   <= sat_val;
                tens  <= 4'd0;
            end else if (state == S_CONVERT) begin
                if (rem >= 7'd10) begin
                    rem  <= rem - 7'd10;
                    tens <= tens + 4'd1;
                end else begin
                    d1 <= tens_digit;
                    d0 <= rem[3:0];
                end
            end
        end
    end

endmodule

// File: tb/tb_sevenseg_display_ctrl.sv
// Directed bench for sevenseg_display_ctrl with a transaction-level display model
// checked every cycle on the falling edge.
module tb_sevenseg_display_ctrl;

    localparam int CLK_DIV     = 4;
    localparam int HOLD_CYCLES = 20;
`ifdef SEVENSEG_LEAD_BLANK_EN
    localparam logic [3:0] LZ = 4'hF;
`else
    localparam logic [3:0] LZ = 4'h0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       tmr_req = 1'b0;
    logic [6:0] tmr_val = 7'd0;
    logic       score_req = 1'b0;
    logic [6:0] score_val = 7'd0;
    logic       tmr_gnt, score_gnt, owner, busy, scan_en;
    logic [3:0] d3, d2, d1, d0;

    int checks = 0;
    int errors = 0;

    sevenseg_display_ctrl #(.CLK_DIV(CLK_DIV), .HOLD_CYCLES(HOLD_CYCLES)) dut (
        .clk(clk), .rst(rst),
        .tmr_req(tmr_req), .tmr_val(tmr_val),
        .score_req(score_req), .score_val(score_val),
        .tmr_gnt(tmr_gnt), .score_gnt(score_gnt),
        .owner(owner), .busy(busy), .scan_en(scan_en),
        .d3(d3), .d2(d2), .d1(d1), .d0(d0)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    // Display model: on a grant, the value's decimal digits appear after tens+1 busy cycles.
    int         pcount = 0;
    int         conv_left = 0;
    logic [3:0] exp_d1 = 4'hF, exp_d0 = 4'hF, new_d1 = 4'hF, new_d0 = 4'hF;
    logic       exp_owner = 1'b0;

    task automatic model_grant(input logic [6:0] val, input logic src);
        int v;
        v = (int'(val) > 99) ? 99 : int'(val);
        chk("gnt_while_busy", conv_left, 0);
        new_d1    = (v / 10 == 0) ? LZ : 4'(v / 10);
        new_d0    = 4'(v % 10);
        conv_left = v / 10 + 1;
        exp_owner = src;
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            pcount = 0; conv_left = 0; exp_owner = 1'b0;
            exp_d1 = 4'hF; exp_d0 = 4'hF;
            chk("rst_scan_en", scan_en, 0);
            chk("rst_gnts", {tmr_gnt, score_gnt}, 0);
            chk("rst_busy", busy, 0);
            chk("rst_owner", owner, 0);
            chk("rst_digits", {d3, d2, d1, d0}, 16'hFFFF);
        end else begin
            pcount++;
            chk("mon_scan_en", scan_en, (pcount % CLK_DIV) == CLK_DIV - 1);
            chk("mon_two_gnts", tmr_gnt & score_gnt, 0);
            if (tmr_gnt) model_grant(tmr_val, 1'b0);
            else if (score_gnt) model_grant(score_val, 1'b1);
            chk("mon_busy", busy, conv_left > 0);
            chk("mon_owner", owner, exp_owner);
            chk("mon_d3d2", {d3, d2}, 8'hFF);
            chk("mon_d1", d1, exp_d1);
            chk("mon_d0", d0, exp_d0);
            if (conv_left > 0) begin
                conv_left--;
                if (conv_left == 0) begin
                    exp_d1 = new_d1;
                    exp_d0 = new_d0;
                end
            end
        end
    end

    task automatic do_reset();
        @(negedge clk);
        #2;
        rst = 1'b0; tmr_req = 1'b0; score_req = 1'b0;
        repeat (3) @(negedge clk);
        #2 rst = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic set_req(input logic src, input logic [6:0] val);
        @(negedge clk);
        #2;
        if (src) begin score_req = 1'b1; score_val = val; end
        else begin tmr_req = 1'b1; tmr_val = val; end
    endtask

    // Returns at the falling edge where the grant is visible, then drops that request.
    task automatic wait_gnt(input string name, input logic src, input int max, output int lat);
        logic hit;
        lat = 0;
        hit = 1'b0;
        while (!hit && lat < max) begin
            @(negedge clk);
            lat++;
            hit = src ? score_gnt : tmr_gnt;
            if (src ? tmr_gnt : score_gnt) chk({name, "_wrong_gnt"}, 1, 0);
        end
        if (!hit) chk({name, "_gnt_timeout"}, 0, 1);
        #2;
        if (src) score_req = 1'b0; else tmr_req = 1'b0;
    endtask

    task automatic count_busy(output int bc);
        bc = 1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (!busy) break;
            bc++;
        end
    endtask

    int lat, bc, gap;

    initial begin
        // 1: reset, then scan_en in the 4th/8th/12th cycle counting the release cycle as 1
        repeat (3) @(negedge clk);
        #2 rst = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            chk("t1_scan", scan_en, (k == 3) || (k == 7) || (k == 11));
        end

        // 2: timer 37 from IDLE
        set_req(1'b0, 7'd37);
        wait_gnt("t2", 1'b0, 10, lat);
        chk("t2_gnt_lat", lat, 1);
        count_busy(bc);
        chk("t2_busy_cycles", bc, 4);
        chk("t2_digits", {d1, d0}, {4'd3, 4'd7});
        chk("t2_owner", owner, 0);

        // 3: tie in IDLE, then score after the hold time
        do_reset();
        @(negedge clk);
        #2;
        tmr_req = 1'b1; tmr_val = 7'd12; score_req = 1'b1; score_val = 7'd45;
        wait_gnt("t3t", 1'b0, 10, lat);
        chk("t3_tie_lat", lat, 1);
        count_busy(bc);
        chk("t3_busy12", bc, 2);
        chk("t3_digits12", {d1, d0}, {4'd1, 4'd2});
        gap = bc;
        wait_gnt("t3s", 1'b1, 80, lat);
        gap += lat;
        chk("t3_hold_min", gap >= HOLD_CYCLES, 1);
        chk("t3_hold_bounded", gap <= HOLD_CYCLES + 12, 1);
        count_busy(bc);
        chk("t3_busy45", bc, 5);
        chk("t3_digits45", {d1, d0}, {4'd4, 4'd5});
        chk("t3_owner", owner, 1);

        // 4: saturation and zero
        do_reset();
        set_req(1'b0, 7'd120);
        wait_gnt("t4a", 1'b0, 10, lat);
        count_busy(bc);
        chk("t4_busy99", bc, 10);
        chk("t4_digits99", {d1, d0}, {4'd9, 4'd9});
        set_req(1'b0, 7'd0);
        wait_gnt("t4b", 1'b0, 10, lat);
        chk("t4_refresh_lat", lat, 1);
        count_busy(bc);
        chk("t4_busy0", bc, 1);
        chk("t4_digits0", {d1, d0}, {LZ, 4'd0});

        // 5: owner refresh while the other request waits on hold
        do_reset();
        set_req(1'b0, 7'd9);
        wait_gnt("t5a", 1'b0, 10, lat);
        count_busy(bc);
        chk("t5_digits09", {d1, d0}, {LZ, 4'd9});
        set_req(1'b1, 7'd55);
        repeat (2) @(negedge clk);
        set_req(1'b0, 7'd8);
        wait_gnt("t5b", 1'b0, 5, lat);
        chk("t5_refresh_lat", lat, 1);
        count_busy(bc);
        chk("t5_busy08", bc, 1);
        chk("t5_digits08", {d1, d0}, {LZ, 4'd8});
        chk("t5_owner_timer", owner, 0);
        wait_gnt("t5c", 1'b1, 80, lat);
        count_busy(bc);
        chk("t5_digits55", {d1, d0}, {4'd5, 4'd5});

        // 6: asynchronous reset in the middle of a conversion
        do_reset();
        set_req(1'b0, 7'd42);
        wait_gnt("t6a", 1'b0, 10, lat);
        count_busy(bc);
        chk("t6_digits42", {d1, d0}, {4'd4, 4'd2});
        set_req(1'b0, 7'd95);
        wait_gnt("t6b", 1'b0, 10, lat);
        repeat (3) @(negedge clk);
        chk("t6_busy_before", busy, 1);
        #2 rst = 1'b0;
        #1;
        chk("t6_async_digits", {d1, d0}, 8'hFF);
        chk("t6_async_busy", busy, 0);
        chk("t6_async_owner", owner, 0);
        repeat (2) @(negedge clk);
        #2 rst = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("t6_no_gnt", {tmr_gnt, score_gnt, busy}, 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

endmodule
